mux_scan_reg: RTL and testbench
===============================

// Module: mux_scan_reg
// PURPOSE
//  Parametrised successor to the 4:1 bootcamp mux: N-channel, WIDTH-bit mux with a registered
//  output and valid/ready handshake. Two modes: MANUAL (capture the channel picked by sel on a
//  load strobe) and SCAN (round-robin sampling of every channel on a fixed hold interval).
//  Sits between parallel sample sources and a single downstream consumer.
// PARAMETERS
//  WIDTH      4   bits per channel
//  CH         4   number of input channels (>=2)
//  SEL_W      2   channel index width, = $clog2(CH)
//  SCAN_HOLD  4   cycles between samples in SCAN mode (>=1)
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous reset, active low
//  in_data   in   CH*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//  mode      in   1          0 = MANUAL, 1 = SCAN
//  sel       in   SEL_W      channel index (MANUAL only)
//  sel_load  in   1          MANUAL capture strobe, one cycle
//  out_data  out  WIDTH      registered sample
//  out_ch    out  SEL_W      channel index of out_data
//  out_valid out  1          out_data/out_ch hold a sample
//  out_ready in   1          consumer accepts when out_valid & out_ready
//  sel_err   out  1          one-cycle pulse: load with sel >= CH
// BEHAVIOUR
//  - Reset (async assert, sync release): out_data=0, out_ch=0, out_valid=0, sel_err=0,
//    scan pointer=0, hold counter=0, state=MANUAL.
//  - Output register is free when !out_valid or (out_valid & out_ready) in that cycle.
//  - States: MANUAL, SCAN. The state follows mode each cycle; on any change, hold counter
//    clears to 0. Scan pointer is kept across mode changes.
//  - MANUAL: sel_load at edge N with register free -> out_data=in_data[sel], out_ch=sel,
//    out_valid=1 after edge N (1-cycle latency). sel_load while not free is dropped, with no
//    queueing. sel >= CH: no capture, sel_err=1 for one cycle.
//  - SCAN: hold counter counts 0..SCAN_HOLD-1. When it reaches SCAN_HOLD-1 with the register
//    free: capture in_data[ptr], out_ch=ptr, out_valid=1, ptr advances (CH-1 wraps to 0),
//    counter returns to 0. If not free at that point, the counter holds at SCAN_HOLD-1 and ptr
//    does not move. No channel is skipped under backpressure.
//  - sel_load and sel are ignored in SCAN, and sel_err stays 0.
//  - out_valid clears only on an accepted transfer with no new capture in the same cycle.
//    An accept and a capture in the same cycle leave out_valid=1 with the new data.
//  - out_data/out_ch are stable while out_valid & !out_ready.
//  - in_data is sampled only on the capture edge; changes at other times have no effect.
//  - Reset mid-operation discards any pending sample. Outputs go to reset values immediately.
// TESTING (WIDTH=4, CH=4, SCAN_HOLD=4; in_data ch0..3 = 4,8,12,15; out_ready=1 unless noted)
//  1 MANUAL: sel_load with sel=0,1,2,3 on successive cycles -> next-cycle out_data 4,8,12,15,
//    out_ch 0..3, out_valid=1.
//  2 SCAN from reset: mode=1 -> out_data 4,8,12,15,4 captured every 4 cycles, out_ch wraps 3->0.
//  3 Backpressure in SCAN: out_ready=0 for 10 cycles after ch1 capture -> out_data holds 8,
//    then with out_ready=1 the next sample is 12 (ch2 not skipped).
//  4 MANUAL load while stalled (out_valid=1, out_ready=0), sel=3 -> dropped, out_data unchanged.
//  5 CH=3 build, MANUAL sel=3 with sel_load -> sel_err pulses 1 cycle, no capture.
//  6 rst_n low mid-SCAN between captures -> out_valid=0, out_data=0 immediately. After release,
//    the first capture is ch0=4 after 4 cycles.

Source files
------------

// File: rtl/mux_scan_reg.sv
// mux_scan_reg
//   N-channel, WIDTH-bit mux with a registered output and valid/ready handshake.
//   MANUAL mode captures the channel named by sel on a sel_load strobe; SCAN mode
//   samples every channel round-robin, one capture per SCAN_HOLD cycles.
// Ports
//   clk, rst_n     clock, async active-low reset (sync release expected upstream)
//   in_data        CH packed channels, channel k at [k*WIDTH +: WIDTH]
//   mode           0 = MANUAL, 1 = SCAN
//   sel, sel_load  MANUAL channel index and one-cycle capture strobe
//   out_data/ch    registered sample and the channel it came from
//   out_valid      sample present; consumed when out_valid & out_ready
//   sel_err        one-cycle pulse when a MANUAL load names a channel >= CH
module mux_scan_reg #(
  parameter int WIDTH     = 4,
  parameter int CH        = 4,
  parameter int SEL_W     = 2,
  parameter int SCAN_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH*WIDTH-1:0]   in_data,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_load,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_t;

  localparam int                CNT_W    = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_HOLD - 1);
  localparam logic [SEL_W-1:0]  PTR_LAST = SEL_W'(CH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               sel_err_q, sel_err_d;
  logic               sel_ok;
  logic               free;

  // When CH fills the whole index space every sel value is legal; testing
  // sel < CH there would be a constant compare.
  generate
    if (CH == (1 << SEL_W)) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_part
      localparam logic [SEL_W-1:0] CH_L = SEL_W'(CH);
      assign sel_ok = (sel < CH_L);
    end
  endgenerate

  // Channel select without slicing past the end of in_data for illegal indices.
  function automatic logic [WIDTH-1:0] pick(input logic [CH*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0]    idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      if (idx == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_t'(mode);
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = 1'b0;

    // Accepted transfer empties the register unless a capture below refills it.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (!mode) begin
      cnt_d = '0;
      if (sel_load) begin
        if (!sel_ok) begin
          sel_err_d = 1'b1;
        end else if (free) begin
          out_data_d  = pick(in_data, sel);
          out_ch_d    = sel;
          out_valid_d = 1'b1;
        end
      end
    end else begin
      if (state_q != ST_SCAN) begin
        // Mode change cycle: restart the hold interval, pointer is kept.
        cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (free) begin
        out_data_d  = pick(in_data, ptr_q);
        out_ch_d    = ptr_q;
        out_valid_d = 1'b1;
        ptr_d       = (ptr_q == PTR_LAST) ? '0 : ptr_q + SEL_W'(1);
        cnt_d       = '0;
      end
      // Otherwise stalled at CNT_LAST: hold counter and pointer so no channel is skipped.
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_MANUAL;
      cnt_q       <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: a CH=4 instance for the main scenarios and a
// CH=3 instance for the out-of-range select pulse.
module tb_mux_scan_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        mode, sel_load, out_ready;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid, sel_err;

  logic [11:0] in_data3;
  logic        mode3, sel_load3, out_ready3;
  logic [1:0]  sel3;
  logic [3:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3, sel_err3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_scan_reg #(.WIDTH(4), .CH(4), .SEL_W(2), .SCAN_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .mode(mode), .sel(sel),
    .sel_load(sel_load), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_scan_reg #(.WIDTH(4), .CH(3), .SEL_W(2), .SCAN_HOLD(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .mode(mode3), .sel(sel3),
    .sel_load(sel_load3), .out_data(out_data3), .out_ch(out_ch3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_d [5];
  logic [1:0] exp_c [5];

  initial begin
    exp_d = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd4};
    exp_c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    in_data  = {4'd15, 4'd12, 4'd8, 4'd4};
    in_data3 = {4'd12, 4'd8, 4'd4};
    mode = 0; sel = 0; sel_load = 0; out_ready = 1;
    mode3 = 0; sel3 = 0; sel_load3 = 0; out_ready3 = 1;
    rst_n = 0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_ch",    32'(out_ch), 0);
    chk("rst_err",   32'(sel_err), 0);
    @(negedge clk);
    rst_n = 1;

    // 1: MANUAL loads on successive cycles
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); sel_load = 1;
      step();
      chk($sformatf("man_data%0d", k), 32'(out_data), 32'(exp_d[k]));
      chk($sformatf("man_ch%0d", k),   32'(out_ch), 32'(k));
      chk($sformatf("man_vld%0d", k),  32'(out_valid), 1);
    end
    sel_load = 0;
    step();
    chk("man_drain", 32'(out_valid), 0);

    // 4: load while stalled is dropped
    sel = 1; sel_load = 1; out_ready = 0;
    step();
    chk("stall_cap", 32'(out_data), 8);
    sel = 3;
    step();
    chk("stall_drop_data", 32'(out_data), 8);
    chk("stall_drop_ch",   32'(out_ch), 1);
    chk("stall_vld",       32'(out_valid), 1);
    sel_load = 0; out_ready = 1;
    step();
    chk("stall_release", 32'(out_valid), 0);

    // 5: CH=3 instance, illegal select
    sel3 = 3; sel_load3 = 1;
    step();
    chk("ch3_err_pulse", 32'(sel_err3), 1);
    chk("ch3_no_cap",    32'(out_valid3), 0);
    sel_load3 = 0;
    step();
    chk("ch3_err_clear", 32'(sel_err3), 0);
    sel3 = 2; sel_load3 = 1;
    step();
    chk("ch3_legal_data", 32'(out_data3), 12);
    chk("ch3_legal_err",  32'(sel_err3), 0);
    sel_load3 = 0;

    // 2: SCAN from reset, one capture every 4 cycles, wraps 3 -> 0
    do_reset();
    mode = 1; sel_load = 1; sel = 2;  // ignored in SCAN
    step();  // mode change edge
    for (int i = 0; i < 5; i++) begin
      repeat (3) step();
      chk($sformatf("scan_gap%0d", i), 32'(out_valid), 0);
      step();
      chk($sformatf("scan_data%0d", i), 32'(out_data), 32'(exp_d[i]));
      chk($sformatf("scan_ch%0d", i),   32'(out_ch), 32'(exp_c[i]));
      chk($sformatf("scan_err%0d", i),  32'(sel_err), 0);
    end
    sel_load = 0;

    // 3: backpressure after ch1 capture, ch2 not skipped
    do_reset();
    step();
    repeat (3) step();
    step();
    chk("bp_ch0", 32'(out_data), 4);
    repeat (3) step();
    step();
    chk("bp_ch1", 32'(out_data), 8);
    out_ready = 0;
    repeat (10) step();
    chk("bp_hold_data", 32'(out_data), 8);
    chk("bp_hold_vld",  32'(out_valid), 1);
    out_ready = 1;
    step();
    chk("bp_next_data", 32'(out_data), 12);
    chk("bp_next_ch",   32'(out_ch), 2);

    // 6: reset mid-SCAN with a sample pending
    do_reset();
    step();
    repeat (3) step();
    out_ready = 0;
    step();
    chk("mid_cap", 32'(out_data), 4);
    repeat (2) step();
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_vld",  32'(out_valid), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    out_ready = 1;
    @(negedge clk);
    rst_n = 1;
    step();  // mode change edge after release
    repeat (3) step();
    chk("post_rst_gap", 32'(out_valid), 0);
    step();
    chk("post_rst_data", 32'(out_data), 4);
    chk("post_rst_ch",   32'(out_ch), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
